// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential shift-and-add multiplier.
//   state_t     - FSM encoding (IDLE / RUN / DONE; 2'd3 is unused and recovers to IDLE)
//   MULT_W      - operand width, fixed by the 32-bit adder
//   MULT_ITERS  - number of add/shift iterations per multiply
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_W     = 32;
  localparam int MULT_ITERS = 32;

endpackage : mult_pkg

// File: rtl/sum.sv
// sum: 32-bit ripple-carry adder used as the multiplier's only datapath adder.
//   a, b  in   32  addends
//   s     out  32  sum bits
//   cout  out  1   carry out of bit 31
module sum (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        cout
);

  // Carry chain: cy[i] is the carry into bit i, cy[32] is the carry out.
  logic [32:0] cy;

  assign cy[0] = 1'b0;

  // One full adder per bit; built gate-level so the datapath has no '+'.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
  end

  assign cout = cy[32];

endmodule : sum

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential 32x32 unsigned shift-and-add multiplier with a
// start/busy/done handshake. One add+shift iteration per cycle, 32 iterations,
// then a one-cycle done pulse. Throughput is one multiply per 33 cycles.
//   clk      in   1   clock, all state updates on the rising edge
//   rst_n    in   1   synchronous active-low reset
//   start    in   1   multiply request, only honoured in IDLE or DONE
//   a        in   32  multiplicand, captured when start is accepted
//   b        in   32  multiplier, captured when start is accepted
//   busy     out  1   high while iterating
//   done     out  1   one-cycle pulse, product valid in this cycle
//   product  out  64  {hi,q}; held until the next accepted start
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // The adder is hard-wired at 32 bits and the counter has to reach the last
  // iteration index without wrapping, so reject anything else at elaboration.
  if (WIDTH != MULT_W) begin : g_bad_width
    $error("mult_seq_ctrl: WIDTH must be 32");
  end
  if ((2 ** CNT_W) <= MULT_ITERS) begin : g_bad_cnt
    $error("mult_seq_ctrl: CNT_W too small for the iteration count");
  end

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   s;
  logic               c;
  logic               accept;

  // A new multiply may only be accepted from IDLE or DONE; start in RUN is dropped.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  assign addend = m & {WIDTH{q[0]}};

  sum u_sum (
    .a    (hi),
    .b    (addend),
    .s    (s),
    .cout (c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. RUN leaves after the iteration that uses cnt == 31,
  // so the counter never wraps. The unused encoding falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = (cnt == LAST_ITER) ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode directly from the state, so busy and done are exclusive.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath registers. Each RUN cycle shifts {carry, sum, q} right by one:
  // the adder carry lands in hi[31] and the sum LSB moves into q[31], while
  // the consumed multiplier bit drops off the bottom of q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m   <= '0;
      hi  <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (accept) begin
      m   <= a;
      q   <= b;
      hi  <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      {hi, q} <= {c, s, q[WIDTH-1:1]};
      cnt     <= cnt + CNT_W'(1);
    end
  end

  assign product = {hi, q};

endmodule : mult_seq_ctrl

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized self-checking bench for mult_seq_ctrl.
// Expected products come from a plain 64-bit multiply; expected timing comes
// from the handshake rules (busy for 32 cycles, done in the 33rd).
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int errors;
  int overlap;

  mult_seq_ctrl #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tracks any cycle where busy and done are asserted together.
  always @(negedge clk) begin
    if (rst_n && busy && done) overlap++;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents operands with start for one cycle; returns at the negedge of the
  // first cycle after the accepting edge.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB);
    start = 1'b1;
    a     = opA;
    b     = opB;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches one multiply from its first busy cycle through done.
  // noise: 0 quiet, 1 stray start with new operands in cycle 10, 2 random
  // start/operand churn every RUN cycle. chain: hold start across done with
  // the next operands so the following multiply starts without an idle cycle.
  task automatic watchResult(input string tag, input logic [63:0] exp, input int noise,
                             input bit chain, input logic [31:0] nA, input logic [31:0] nB);
    int busyCnt;
    int doneAt;
    busyCnt = 0;
    doneAt  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        doneAt = k;
        checkOutput({tag, "_product"}, product, exp);
        if (chain) begin
          start = 1'b1;
          a     = nA;
          b     = nB;
        end else begin
          start = 1'b0;
        end
        break;
      end
      if (busy) busyCnt++;
      start = 1'b0;
      if (noise == 1 && k == 10) begin
        start = 1'b1;
        a     = ~a;
        b     = b + 32'd3;
      end else if (noise == 2 && k <= 32) begin
        start = 1'($urandom_range(0, 1));
        a     = $urandom;
        b     = $urandom;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, 64'(doneAt), 64'd33);
    checkOutput({tag, "_busycycles"}, 64'(busyCnt), 64'd32);
    @(negedge clk);
    if (chain) begin
      start = 1'b0;
      checkOutput({tag, "_b2b_busy"}, {63'd0, busy}, 64'd1);
    end else begin
      checkOutput({tag, "_hold"}, product, exp);
      checkOutput({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h0;
    if (sel == 1) return 32'hFFFF_FFFF;
    if (sel == 2) return 32'h1;
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    checks  = 0;
    errors  = 0;
    overlap = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_product", product, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic and boundary operands");
    applyStimulus(32'd3, 32'd5);
    watchResult("t1", 64'h0F, 0, 1'b0, '0, '0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    watchResult("t2", 64'hFFFF_FFFE_0000_0001, 0, 1'b0, '0, '0);
    applyStimulus(32'h0, 32'h1234);
    watchResult("t3a", 64'h0, 0, 1'b0, '0, '0);
    applyStimulus(32'h1234, 32'h0);
    watchResult("t3b", 64'h0, 0, 1'b0, '0, '0);

    $display("[TB] start during run is ignored");
    applyStimulus(32'hDEAD_BEEF, 32'h0000_1001);
    watchResult("t4", 64'(32'hDEAD_BEEF) * 64'(32'h0000_1001), 1, 1'b0, '0, '0);

    $display("[TB] reset aborts a multiply");
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 1; k < 15; k++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_busy", {63'd0, busy}, 64'd0);
    checkOutput("t5_done", {63'd0, done}, 64'd0);
    checkOutput("t5_product", product, 64'd0);
    applyStimulus(32'd7, 32'd6);
    watchResult("t5_after", 64'd42, 0, 1'b0, '0, '0);

    $display("[TB] back-to-back multiplies");
    applyStimulus(32'h0001_0000, 32'h0001_0000);
    watchResult("t6a", 64'h1_0000_0000, 0, 1'b1, 32'd9, 32'd9);
    watchResult("t6b", 64'd81, 0, 1'b0, '0, '0);

    $display("[TB] random operands");
    for (int i = 0; i < 1000; i++) begin
      ra = pickOperand();
      rb = pickOperand();
      applyStimulus(ra, rb);
      watchResult("rand", 64'(ra) * 64'(rb), int'($urandom_range(0, 2)), 1'b0, '0, '0);
    end

    checkOutput("busy_done_exclusive", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult_seq_ctrl
